// File: rtl/alu_req_driver.sv
// ALU operand-protocol initiator: takes one request over valid/ready, drives the ALU
// pins in one or two beats, waits the ALU latency, and returns RES and flags over valid/ready.
`timescale 1ns/1ps
module alu_req_driver #(
  parameter int WIDTH   = 8,
  parameter int CWIDTH  = 4,
  parameter int LAT     = 1,
  parameter int MUL_LAT = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_mode,
  input  logic [CWIDTH-1:0]  req_cmd,
  input  logic               req_cin,
  input  logic [WIDTH-1:0]   req_opa,
  input  logic [WIDTH-1:0]   req_opb,
  input  logic [1:0]         req_ops,
  input  logic               req_split,
  input  logic [3:0]         req_gap,
  output logic               CE,
  output logic               MODE,
  output logic               CIN,
  output logic [CWIDTH-1:0]  CMD,
  output logic [1:0]         INP_VALID,
  output logic [WIDTH-1:0]   OPA,
  output logic [WIDTH-1:0]   OPB,
  input  logic [2*WIDTH-1:0] RES,
  input  logic               COUT,
  input  logic               OFLOW,
  input  logic               G,
  input  logic               E,
  input  logic               L,
  input  logic               ERR,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [2*WIDTH-1:0] resp_res,
  output logic [5:0]         resp_flags
);

  typedef enum logic [2:0] {IDLE, BEAT_A, GAP, BEAT_B, WAIT, RESP} state_t;

  state_t           state;
  logic [4:0]       cnt;
  logic [3:0]       gap_r;
  logic [WIDTH-1:0] opb_r;
  logic             mul_r;
  logic [1:0]       ops_n;
  logic             is_mul;

  // An all-zero operand mask means "both operands".
  function automatic logic [1:0] norm_ops(input logic [1:0] ops);
    return (ops == 2'b00) ? 2'b11 : ops;
  endfunction

  assign ops_n  = norm_ops(req_ops);
  assign is_mul = req_mode && ((req_cmd == CWIDTH'(9)) || (req_cmd == CWIDTH'(10)));

  // Outputs are registered for the state being entered, so each beat appears right after its edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      gap_r      <= 4'd0;
      opb_r      <= '0;
      mul_r      <= 1'b0;
      req_ready  <= 1'b0;
      CE         <= 1'b0;
      MODE       <= 1'b0;
      CIN        <= 1'b0;
      CMD        <= '0;
      INP_VALID  <= 2'b00;
      OPA        <= '0;
      OPB        <= '0;
      resp_valid <= 1'b0;
      resp_res   <= '0;
      resp_flags <= 6'd0;
    end else if (flush) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      gap_r      <= 4'd0;
      opb_r      <= '0;
      mul_r      <= 1'b0;
      req_ready  <= 1'b0;
      CE         <= 1'b0;
      MODE       <= 1'b0;
      CIN        <= 1'b0;
      CMD        <= '0;
      INP_VALID  <= 2'b00;
      OPA        <= '0;
      OPB        <= '0;
      resp_valid <= 1'b0;
      resp_res   <= '0;
      resp_flags <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            gap_r     <= req_gap;
            opb_r     <= req_opb;
            mul_r     <= is_mul;
            CE        <= 1'b1;
            MODE      <= req_mode;
            CMD       <= req_cmd;
            CIN       <= req_cin;
            if (req_split && (ops_n == 2'b11)) begin
              state     <= BEAT_A;
              INP_VALID <= 2'b01;
              OPA       <= req_opa;
              OPB       <= '0;
            end else begin
              state     <= BEAT_B;
              INP_VALID <= ops_n;
              OPA       <= ops_n[0] ? req_opa : '0;
              OPB       <= ops_n[1] ? req_opb : '0;
            end
          end
        end
        BEAT_A: begin
          OPA <= '0;
          if (gap_r != 4'd0) begin
            state     <= GAP;
            cnt       <= {1'b0, gap_r};
            INP_VALID <= 2'b00;
          end else begin
            state     <= BEAT_B;
            INP_VALID <= 2'b10;
            OPB       <= opb_r;
          end
        end
        GAP: begin
          if (cnt == 5'd1) begin
            state     <= BEAT_B;
            INP_VALID <= 2'b10;
            OPB       <= opb_r;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        BEAT_B: begin
          state     <= WAIT;
          INP_VALID <= 2'b00;
          OPA       <= '0;
          OPB       <= '0;
          cnt       <= mul_r ? 5'(MUL_LAT) : 5'(LAT);
        end
        WAIT: begin
          // Capture cycle is the last one with CE high.
          if (cnt <= 5'd1) begin
            state      <= RESP;
            resp_res   <= RES;
            resp_flags <= {COUT, OFLOW, G, E, L, ERR};
            resp_valid <= 1'b1;
            CE         <= 1'b0;
            MODE       <= 1'b0;
            CMD        <= '0;
            CIN        <= 1'b0;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_driver.sv
// Directed self-checking bench for alu_req_driver; the bench acts as the ALU stub.
`timescale 1ns/1ps
module tb_alu_req_driver;
  localparam int WIDTH  = 8;
  localparam int CWIDTH = 4;

  logic CLK = 1'b0;
  logic RST, flush, req_valid, req_ready, req_mode, req_cin, req_split;
  logic [CWIDTH-1:0] req_cmd;
  logic [WIDTH-1:0]  req_opa, req_opb;
  logic [1:0]        req_ops;
  logic [3:0]        req_gap;
  logic CE, MODE, CIN;
  logic [CWIDTH-1:0] CMD;
  logic [1:0]        INP_VALID;
  logic [WIDTH-1:0]  OPA, OPB;
  logic [2*WIDTH-1:0] RES;
  logic COUT, OFLOW, G, E, L, ERR;
  logic resp_valid, resp_ready;
  logic [2*WIDTH-1:0] resp_res;
  logic [5:0] resp_flags;

  int checks   = 0;
  int failures = 0;
  int bad;

  alu_req_driver #(.WIDTH(WIDTH), .CWIDTH(CWIDTH), .LAT(1), .MUL_LAT(2)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_cmd(req_cmd), .req_cin(req_cin),
    .req_opa(req_opa), .req_opb(req_opb), .req_ops(req_ops),
    .req_split(req_split), .req_gap(req_gap),
    .CE(CE), .MODE(MODE), .CIN(CIN), .CMD(CMD), .INP_VALID(INP_VALID),
    .OPA(OPA), .OPB(OPB), .RES(RES),
    .COUT(COUT), .OFLOW(OFLOW), .G(G), .E(E), .L(L), .ERR(ERR),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_res(resp_res), .resp_flags(resp_flags)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input logic m, input logic [3:0] c, input logic ci,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] ops, input logic sp, input logic [3:0] gp);
    req_mode = m; req_cmd = c; req_cin = ci; req_opa = a; req_opb = b;
    req_ops = ops; req_split = sp; req_gap = gp; req_valid = 1'b1;
  endtask

  initial begin
    RST = 1'b1; flush = 1'b0; req_valid = 1'b0; req_mode = 1'b0; req_cin = 1'b0;
    req_split = 1'b0; req_cmd = '0; req_opa = '0; req_opb = '0; req_ops = 2'b00;
    req_gap = 4'd0; RES = '0; COUT = 1'b0; OFLOW = 1'b0; G = 1'b0; E = 1'b0;
    L = 1'b0; ERR = 1'b0; resp_ready = 1'b1;

    // Reset state
    #12;
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check_eq("rst_ce_iv", {29'd0, CE, INP_VALID}, 32'd0);
    check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    tick();
    RST = 1'b0;
    tick();
    check_eq("rel_req_ready", {31'd0, req_ready}, 32'd1);

    // Unsplit ADD
    set_req(1'b1, 4'd0, 1'b0, 8'h0F, 8'h01, 2'b11, 1'b0, 4'd0);
    tick();
    req_valid = 1'b0;
    check_eq("add_beat_iv_ce", {29'd0, CE, INP_VALID}, 32'h7);
    check_eq("add_beat_ops", {16'd0, OPA, OPB}, 32'h0F01);
    check_eq("add_mode_cmd", {27'd0, MODE, CMD}, 32'h10);
    check_eq("add_req_ready", {31'd0, req_ready}, 32'd0);
    RES = 16'h0010; E = 1'b1;
    tick();
    check_eq("add_wait", {28'd0, resp_valid, CE, INP_VALID}, 32'h4);
    tick();
    check_eq("add_resp_valid_ce", {30'd0, resp_valid, CE}, 32'h2);
    check_eq("add_resp_res", {16'd0, resp_res}, 32'h0010);
    check_eq("add_resp_flags", {26'd0, resp_flags}, 32'h04);
    RES = '0; E = 1'b0;
    tick();
    check_eq("add_after_hs", {30'd0, resp_valid, req_ready}, 32'h1);

    // Split, gap 15
    set_req(1'b0, 4'd3, 1'b1, 8'hAA, 8'h55, 2'b11, 1'b1, 4'd15);
    tick();
    req_valid = 1'b0;
    check_eq("split_a_iv_ce", {29'd0, CE, INP_VALID}, 32'h5);
    check_eq("split_a_ops", {16'd0, OPA, OPB}, 32'hAA00);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (INP_VALID !== 2'b00 || CE !== 1'b1 || CMD !== 4'd3 || CIN !== 1'b1) bad++;
    end
    check_eq("split_gap_hold", bad, 32'd0);
    tick();
    check_eq("split_b_iv", {30'd0, INP_VALID}, 32'h2);
    check_eq("split_b_ops", {16'd0, OPA, OPB}, 32'h0055);
    RES = 16'h00FF;
    tick();
    check_eq("split_wait", {31'd0, resp_valid}, 32'd0);
    tick();
    check_eq("split_resp", {15'd0, resp_valid, resp_res}, 32'h100FF);
    tick();
    RES = '0;

    // Multiply: capture after MUL_LAT, early stub value ignored
    set_req(1'b1, 4'd9, 1'b0, 8'h12, 8'h34, 2'b11, 1'b0, 4'd0);
    tick();
    req_valid = 1'b0;
    check_eq("mul_beat_iv", {30'd0, INP_VALID}, 32'h3);
    tick();
    RES = 16'hDEAD;
    check_eq("mul_wait1", {31'd0, resp_valid}, 32'd0);
    tick();
    check_eq("mul_wait2", {31'd0, resp_valid}, 32'd0);
    RES = 16'h1234;
    tick();
    check_eq("mul_resp", {15'd0, resp_valid, resp_res}, 32'h11234);
    tick();
    RES = '0;

    // Single operand A only (split ignored)
    set_req(1'b0, 4'd1, 1'b0, 8'h80, 8'h77, 2'b01, 1'b1, 4'd4);
    tick();
    req_valid = 1'b0;
    check_eq("single_iv", {30'd0, INP_VALID}, 32'h1);
    check_eq("single_ops", {16'd0, OPA, OPB}, 32'h8000);
    RES = 16'h0080;
    tick();
    check_eq("single_no_2nd_beat", {30'd0, INP_VALID}, 32'h0);
    tick();
    check_eq("single_resp", {15'd0, resp_valid, resp_res}, 32'h10080);
    tick();

    // Backpressure
    resp_ready = 1'b0;
    set_req(1'b0, 4'd2, 1'b0, 8'h03, 8'h01, 2'b11, 1'b0, 4'd0);
    tick();
    req_valid = 1'b0;
    RES = 16'h0002;
    tick();
    tick();
    check_eq("bp_resp", {15'd0, resp_valid, resp_res}, 32'h10002);
    RES = 16'hFFFF;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp_valid !== 1'b1 || resp_res !== 16'h0002 || req_ready !== 1'b0) bad++;
    end
    check_eq("bp_hold", bad, 32'd0);
    resp_ready = 1'b1;
    tick();
    check_eq("bp_after_hs", {30'd0, resp_valid, req_ready}, 32'h1);
    set_req(1'b1, 4'd1, 1'b0, 8'h05, 8'h06, 2'b11, 1'b0, 4'd0);
    tick();
    req_valid = 1'b0;
    check_eq("b2b_beat", {22'd0, INP_VALID, OPA}, 32'h305);
    RES = 16'h000B;
    tick();
    tick();
    check_eq("b2b_resp", {15'd0, resp_valid, resp_res}, 32'h1000B);
    tick();
    RES = '0;

    // RST during GAP
    set_req(1'b0, 4'd4, 1'b0, 8'h11, 8'h22, 2'b11, 1'b1, 4'd5);
    tick();
    req_valid = 1'b0;
    check_eq("rstgap_a", {30'd0, INP_VALID}, 32'h1);
    tick();
    tick();
    check_eq("rstgap_in_gap", {29'd0, CE, INP_VALID}, 32'h4);
    #2;
    RST = 1'b1;
    #1;
    check_eq("rstgap_async", {28'd0, resp_valid, req_ready, CE, INP_VALID}, 32'h0);
    tick();
    tick();
    RST = 1'b0;
    tick();
    check_eq("rstgap_ready", {31'd0, req_ready}, 32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (resp_valid !== 1'b0 || CE !== 1'b0) bad++;
    end
    check_eq("rstgap_no_resp", bad, 32'd0);

    // flush during GAP
    set_req(1'b0, 4'd4, 1'b0, 8'h11, 8'h22, 2'b11, 1'b1, 4'd5);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check_eq("flush_in_gap", {29'd0, CE, INP_VALID}, 32'h4);
    flush = 1'b1;
    tick();
    check_eq("flush_outs", {28'd0, resp_valid, req_ready, CE, INP_VALID}, 32'h0);
    flush = 1'b0;
    tick();
    check_eq("flush_ready", {31'd0, req_ready}, 32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (resp_valid !== 1'b0 || CE !== 1'b0) bad++;
    end
    check_eq("flush_no_resp", bad, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
